// File: rtl/font_pkg.sv
// font_pkg: constants and types shared by the glyph memory loader, the font
// lookup and the text renderer.
//   FONT_W_DFLT / FONT_H_DFLT : default glyph size in pixels
//   NGLYPH / FIRST_CHAR       : printable ASCII range held in the glyph memory
//   ADDR_W                    : glyph memory address width
//   font_nbytes()             : bytes needed to carry one packed glyph word
//   loader_state_t            : loader FSM state encoding
package font_pkg;

    localparam int unsigned FONT_W_DFLT = 10;
    localparam int unsigned FONT_H_DFLT = 12;
    localparam int unsigned NGLYPH      = 95;
    localparam int unsigned FIRST_CHAR  = 32;
    localparam int unsigned ADDR_W      = $clog2(NGLYPH);

    function automatic int unsigned font_nbytes(input int unsigned wbits);
        return (wbits + 7) / 8;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_CKSUM,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/font_word_assembler.sv
// font_word_assembler: packs a byte stream into one glyph word, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : restart at byte 0 (word contents cleared)
//   i_push     : store i_byte into the current byte lane and advance
//   i_byte     : incoming byte
//   o_word     : assembled word (bits at or above WBITS are dropped)
//   o_last     : the current byte lane is the final one of the word
module font_word_assembler #(
    parameter int unsigned WBITS  = 120,
    parameter int unsigned NBYTES = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [7:0]       i_byte,
    output logic [WBITS-1:0] o_word,
    output logic             o_last
);

    localparam int unsigned CW = $clog2(NBYTES + 1);

    logic [8*NBYTES-1:0] r_word;
    logic [CW-1:0]       r_cnt;

    assign o_last = (r_cnt == CW'(NBYTES - 1));
    assign o_word = r_word[WBITS-1:0];

    // Every lane is rewritten for each glyph, so the word needs no clearing
    // between glyphs; only the lane counter wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_push) begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (r_cnt == CW'(k)) begin
                    r_word[8*k +: 8] <= i_byte;
                end
            end
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/font_mem_loader.sv
// font_mem_loader: writer side of the glyph bitmap memory. Collects a byte
// stream into FONT_W*FONT_H-bit glyph words and writes the 95 printable ASCII
// glyphs to addresses 0..94 (address 0 = ASCII 32).
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin a load at glyph 0 (only in IDLE or DONE)
//   s_data/s_valid   : input byte stream
//   s_ready          : loader takes s_data this cycle
//   wr_en/addr/data  : glyph memory write port, one strobe per glyph
//   busy             : load in progress
//   done             : all glyphs written, held until next start
//   err              : checksum mismatch, held until next start
// Optional feature: define FONT_LOADER_CKSUM_EN to expect one trailing byte
// equal to the XOR of all glyph bytes; err reports a mismatch.
module font_mem_loader
    import font_pkg::*;
#(
    parameter int unsigned FONT_W = FONT_W_DFLT,
    parameter int unsigned FONT_H = FONT_H_DFLT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [FONT_W*FONT_H-1:0]  wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned WBITS  = FONT_W * FONT_H;
    localparam int unsigned NBYTES = font_nbytes(WBITS);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [ADDR_W-1:0] r_glyph_cnt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WBITS-1:0]  r_wr_data;
    logic [WBITS-1:0]  w_word;
    logic              w_last;
    logic              w_start_ok;
    logic              w_xfer;
    logic              w_push;
    logic              w_last_glyph;

    assign w_start_ok   = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_xfer       = s_valid & s_ready;
    assign w_push       = w_xfer & (r_state == ST_COLLECT);
    assign w_last_glyph = (r_glyph_cnt == ADDR_W'(NGLYPH - 1));

    font_word_assembler #(
        .WBITS  (WBITS),
        .NBYTES (NBYTES)
    ) u_asm (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_start_ok),
        .i_push (w_push),
        .i_byte (s_data),
        .o_word (w_word),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        s_ready = 1'b0;
        wr_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_push && w_last) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en = 1'b1;
                busy  = 1'b1;
                if (w_last_glyph) begin
`ifdef FONT_LOADER_CKSUM_EN
                    w_next = ST_CKSUM;
`else
                    w_next = ST_DONE;
`endif
                end else begin
                    w_next = ST_COLLECT;
                end
            end
            ST_CKSUM: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_xfer) w_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (w_start_ok) w_next = ST_COLLECT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // The write port shows the live glyph during WRITE and the last written
    // glyph otherwise, so the output is valid in the strobe cycle itself.
    assign wr_addr = wr_en ? r_glyph_cnt : r_wr_addr;
    assign wr_data = wr_en ? w_word      : r_wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glyph_cnt <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else if (w_start_ok) begin
            r_glyph_cnt <= '0;
        end else if (r_state == ST_WRITE) begin
            r_glyph_cnt <= r_glyph_cnt + 1'b1;
            r_wr_addr   <= r_glyph_cnt;
            r_wr_data   <= w_word;
        end
    end

`ifdef FONT_LOADER_CKSUM_EN
    logic [7:0] r_xor;
    logic       r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (w_push) begin
            r_xor <= r_xor ^ s_data;
        end else if ((r_state == ST_CKSUM) && w_xfer) begin
            r_err <= (s_data != r_xor);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
